serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_sub_pkg.sv | 19 +
 rtl/one_bit_subtractor.sv | 17 +
 rtl/serial_subtractor.sv | 129 ++++++++++++
 tb/tb_serial_subtractor.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding, default width and counter sizing helper.
package serial_sub_pkg;

  localparam int SERIAL_SUB_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_e;

  // Bit counter width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    if (w > 1) return $clog2(w);
    return 1;
  endfunction

endpackage

// File: rtl/one_bit_subtractor.sv
// Single-bit full subtractor: D = A - B - Bin.
// Bout is set when the bit position has to borrow from the next one.
module one_bit_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  // Difference and borrow of one bit position.
  always_comb begin
    D    = A ^ B ^ Bin;
    Bout = (~A & B) | (~(A ^ B) & Bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Define SERIAL_SUB_SIGN_MAG_EN for a sign/magnitude result.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SERIAL_SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  sub_state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bor_q, bor_d;
  logic             borrow_out_q, borrow_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic bit_d;
  logic bit_bout;

  one_bit_subtractor u_bit (
    .A    (a_q[cnt_q]),
    .B    (b_q[cnt_q]),
    .Bin  (bor_q),
    .D    (bit_d),
    .Bout (bit_bout)
  );

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      diff_q       <= '0;
      cnt_q        <= '0;
      bor_q        <= 1'b0;
      borrow_out_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      diff_q       <= diff_d;
      cnt_q        <= cnt_d;
      bor_q        <= bor_d;
      borrow_out_q <= borrow_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next-state and datapath updates; busy also covers the done cycle.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    diff_d       = diff_q;
    cnt_d        = cnt_q;
    bor_d        = bor_q;
    borrow_out_d = borrow_out_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start && !busy_q) begin
          a_d          = a;
          b_d          = b;
          bor_d        = 1'b0;
          cnt_d        = '0;
          diff_d       = '0;
          borrow_out_d = 1'b0;
          busy_d       = 1'b1;
          state_d      = SHIFT;
        end
      end
      SHIFT: begin
        diff_d[cnt_q] = bit_d;
        bor_d         = bit_bout;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        done_d       = 1'b1;
        busy_d       = 1'b1;
        borrow_out_d = bor_q;
`ifdef SERIAL_SUB_SIGN_MAG_EN
        if (bor_q) begin
          diff_d = ~diff_q + ONE;
        end
`else
        diff_d = diff_q & ~(ONE & '0);
`endif
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4).
// Directed table, corner sequences and random ops vs. an arithmetic model.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a_i),
    .b          (b_i),
    .diff       (diff),
    .borrow_out (borrow_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] raw;
    logic [W-1:0] mag;
    logic         bor;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pick(input logic [W-1:0] raw,
                                        input logic [W-1:0] mag);
`ifdef SERIAL_SUB_SIGN_MAG_EN
    return mag;
`else
    return raw;
`endif
  endfunction

  // Called at a negedge with the block idle; returns at the negedge
  // one cycle after the done pulse.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input logic eb,
                        input string tag);
    int k;
    start = 1'b1;
    a_i   = av;
    b_i   = bv;
    @(negedge clk);
    start = 1'b0;
    check({tag, " clr_diff"}, int'(diff), 0);
    check({tag, " clr_bor"}, int'(borrow_out), 0);
    check({tag, " busy"}, int'(busy), 1);
    k = 1;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, k, W + 2);
    check({tag, " diff"}, int'(diff), int'(ed));
    check({tag, " borrow"}, int'(borrow_out), int'(eb));
    check({tag, " busy_done"}, int'(busy), 1);
    @(negedge clk);
    check({tag, " done_pulse"}, int'(done), 0);
    check({tag, " busy_end"}, int'(busy), 0);
    check({tag, " hold_diff"}, int'(diff), int'(ed));
    check({tag, " hold_bor"}, int'(borrow_out), int'(eb));
  endtask

  initial begin
    vec_t tbl[8];
    int   ndone;
    logic [W-1:0] fa, fb, ra, rb, exp_raw, exp_mag;
    logic         exp_bor;

    tbl[0] = '{a: 4'd9,  b: 4'd3,  raw: 4'h6, mag: 4'h6, bor: 1'b0};
    tbl[1] = '{a: 4'd3,  b: 4'd9,  raw: 4'hA, mag: 4'h6, bor: 1'b1};
    tbl[2] = '{a: 4'd0,  b: 4'd0,  raw: 4'h0, mag: 4'h0, bor: 1'b0};
    tbl[3] = '{a: 4'd15, b: 4'd15, raw: 4'h0, mag: 4'h0, bor: 1'b0};
    tbl[4] = '{a: 4'd0,  b: 4'd15, raw: 4'h1, mag: 4'hF, bor: 1'b1};
    tbl[5] = '{a: 4'd15, b: 4'd0,  raw: 4'hF, mag: 4'hF, bor: 1'b0};
    tbl[6] = '{a: 4'd8,  b: 4'd7,  raw: 4'h1, mag: 4'h1, bor: 1'b0};
    tbl[7] = '{a: 4'd7,  b: 4'd8,  raw: 4'hF, mag: 4'h1, bor: 1'b1};

    rst   = 1'b1;
    start = 1'b0;
    a_i   = '0;
    b_i   = '0;
    repeat (2) @(negedge clk);
    check("rst diff", int'(diff), 0);
    check("rst bor", int'(borrow_out), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);

    // Reset wins over a simultaneous start.
    start = 1'b1;
    a_i   = 4'd9;
    @(negedge clk);
    check("rst_prio busy", int'(busy), 0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("idle busy", int'(busy), 0);

    // Directed table, issued back to back.
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].b, pick(tbl[i].raw, tbl[i].mag),
             tbl[i].bor, $sformatf("vec%0d", i));
    end

    // Start held high while busy with changing operands.
    fa = 4'd5;
    fb = 4'd12;
    start = 1'b1;
    a_i = fa;
    b_i = fb;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check("busy_start diff", int'(diff), int'(pick(4'h9, 4'h7)));
        check("busy_start bor", int'(borrow_out), 1);
        start = 1'b0;
      end else if (start) begin
        a_i = 4'($urandom_range(0, 15));
        b_i = 4'($urandom_range(0, 15));
      end
    end
    start = 1'b0;
    check("busy_start ndone", ndone, 1);
    @(negedge clk);

    // Reset during the second SHIFT cycle aborts with no done.
    start = 1'b1;
    a_i = 4'd7;
    b_i = 4'd0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort diff", int'(diff), 0);
    check("abort bor", int'(borrow_out), 0);
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort no_done", ndone, 0);
    run_op(4'd12, 4'd5, 4'd7, 1'b0, "after_abort");

    // Random operations against an arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      exp_bor = (int'(ra) < int'(rb));
      exp_raw = 4'((int'(ra) - int'(rb) + 16) % 16);
      exp_mag = exp_bor ? 4'(int'(rb) - int'(ra)) : exp_raw;
      run_op(ra, rb, pick(exp_raw, exp_mag), exp_bor,
             $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
